// File: rtl/mdu_hilo_responder.sv
// Multi-cycle MULT/DIV responder holding the architectural HI/LO registers.
// Ports: clock/reset, operand1/operand2/operation/start in; busy/done/data_read/hi_out/lo_out out.
module mdu_hilo_responder #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [2:0]  operation,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_read,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [3:0]  counter;
  logic [63:0] shadow;
  logic        skipCommit;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic        doneReg;

  logic        accept;
  logic        isLong;
  logic        divZero;
  logic        lastCycle;
  logic [3:0]  runLength;
  logic [31:0] safeDivisor;
  logic [63:0] prodSigned;
  logic [63:0] prodUnsigned;
  logic [31:0] quotSigned;
  logic [31:0] remSigned;
  logic [31:0] quotUnsigned;
  logic [31:0] remUnsigned;
  logic [63:0] result;

  assign accept    = (state == IDLE) && start;
  assign isLong    = operation[2];
  assign divZero   = operation[1] && (operand2 == 32'd0);
  assign lastCycle = (state == RUN) && (counter == 4'd1);
  assign runLength = operation[1] ? 4'(DIV_CYCLES)
                                  : 4'(MULT_CYCLES);

  // Result is computed up front and parked in a shadow register;
  // the counter only models the latency seen by the pipeline.
  assign prodSigned   = {{32{operand1[31]}}, operand1}
                      * {{32{operand2[31]}}, operand2};
  assign prodUnsigned = {32'd0, operand1} * {32'd0, operand2};

  // Substitute a harmless divisor so a zero divide never yields X;
  // the real divide-by-zero case is suppressed at commit time.
  assign safeDivisor = divZero ? 32'd1 : operand2;

  always_comb begin
    quotSigned = 32'($signed(operand1) / $signed(safeDivisor));
    remSigned  = 32'($signed(operand1) % $signed(safeDivisor));
    // Most-negative / -1 overflows; pin the architectural answer.
    if (operand1 == 32'h8000_0000 && operand2 == 32'hFFFF_FFFF) begin
      quotSigned = 32'h8000_0000;
      remSigned  = 32'd0;
    end
  end

  assign quotUnsigned = operand1 / safeDivisor;
  assign remUnsigned  = operand1 % safeDivisor;

  always_comb begin
    result = prodUnsigned;
    case (operation)
      3'd4:    result = prodSigned;
      3'd5:    result = prodUnsigned;
      3'd6:    result = {remSigned, quotSigned};
      3'd7:    result = {remUnsigned, quotUnsigned};
      default: result = prodUnsigned;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (accept && isLong) stateNext = RUN;
      RUN:  if (lastCycle) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = doneReg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter    <= 4'd0;
      shadow     <= 64'd0;
      skipCommit <= 1'b0;
      hiReg      <= 32'd0;
      loReg      <= 32'd0;
      doneReg    <= 1'b0;
    end else begin
      doneReg <= lastCycle;
      if (accept) begin
        if (isLong) begin
          shadow     <= result;
          counter    <= runLength;
          skipCommit <= divZero;
        end else if (operation == 3'd2) begin
          hiReg <= operand1;
        end else if (operation == 3'd3) begin
          loReg <= operand1;
        end
      end else if (state == RUN) begin
        counter <= counter - 4'd1;
        if (lastCycle && !skipCommit) begin
          hiReg <= shadow[63:32];
          loReg <= shadow[31:0];
        end
      end
    end
  end

  assign data_read = (operation == 3'd0) ? hiReg : loReg;
  assign hi_out    = hiReg;
  assign lo_out    = loReg;

endmodule
